// File: rtl/alarm_sched_pkg.sv
// Shared state codes and time constants for the alarm sequencing controller.
// The optional snooze feature is selected with the ALARM_SNOOZE_EN macro in alarm_sched_ctrl.
package alarm_sched_pkg;

   localparam int SEC_PER_HOUR = 3600;
   localparam int SEC_PER_MIN  = 60;
   localparam int DAY_LAST_SEC = 86399;
   localparam int HOUR_MAX     = 23;
   localparam int MIN_MAX      = 59;
   localparam int HOUR_W       = 5;
   localparam int MIN_W        = 6;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SET_HOUR = 3'd1,
      ST_SET_MIN  = 3'd2,
      ST_ARMED    = 3'd3,
      ST_RING     = 3'd4,
      ST_SNOOZE   = 3'd5
   } state_e;

endpackage

// File: rtl/alarm_hm_reg.sv
// Alarm hour/minute registers with wrap-around increments.
// Also converts the setting to seconds-of-day (seconds field always zero).
module alarm_hm_reg
   import alarm_sched_pkg::*;
#(
   parameter int SEC_W        = 17,
   parameter int DEFAULT_HOUR = 1,
   parameter int DEFAULT_MIN  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             hour_inc_i,
   input  logic             min_inc_i,
   output logic [SEC_W-1:0] sec_o
);

   logic [HOUR_W-1:0] hour_q;
   logic [MIN_W-1:0]  min_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hour_q <= HOUR_W'(DEFAULT_HOUR);
         min_q  <= MIN_W'(DEFAULT_MIN);
      end else begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values.
         if (hour_inc_i)
            hour_q <= (hour_q == HOUR_W'(HOUR_MAX)) ? '0 : hour_q + 1'b1;
         if (min_inc_i)
            min_q <= (min_q == MIN_W'(MIN_MAX)) ? '0 : min_q + 1'b1;
      end
   end

   assign sec_o = SEC_W'(hour_q) * SEC_W'(SEC_PER_HOUR)
                + SEC_W'(min_q)  * SEC_W'(SEC_PER_MIN);

endmodule

// File: rtl/alarm_sched_ctrl.sv
// Alarm lifecycle controller: edit -> armed -> ring -> snooze, 10 Hz domain.
// Define ALARM_SNOOZE_EN to build the SNOOZE state; otherwise Key_Adj in RING is ignored.
module alarm_sched_ctrl
   import alarm_sched_pkg::*;
#(
   parameter int SEC_W        = 17,
   parameter int DEFAULT_HOUR = 1,
   parameter int DEFAULT_MIN  = 1,
   parameter int EDIT_TIMEOUT = 100,
   parameter int RING_TICKS   = 600,
   parameter int SNOOZE_TICKS = 3000
) (
   input  logic             Clk_10hz,
   input  logic             n_Global_Rst,
   input  logic             Key_Mode,
   input  logic             Key_Adj,
   input  logic             Key_Stop,
   input  logic             Alarm_En,
   input  logic [SEC_W-1:0] Clock_Sec_Cnt,
   output logic [SEC_W-1:0] Alarm_Sec_Cnt,
   output logic             Ring_Req,
   output logic [1:0]       Edit_Field,
   output logic [2:0]       State
);

   localparam int T_MAX   = (RING_TICKS > EDIT_TIMEOUT) ? RING_TICKS : EDIT_TIMEOUT;
   localparam int CNT_MAX = (SNOOZE_TICKS > T_MAX) ? SNOOZE_TICKS : T_MAX;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] EDIT_LAST   = CNT_W'(EDIT_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_TICKS - 1);
   localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_TICKS - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             eq_q;
   logic             eq, rise, any_key, stop_k, mode_k, adj_k;
   logic             in_edit, timed, edit_tmo;
   logic             hour_inc, min_inc;
   state_e           edit_exit;

   alarm_hm_reg #(
      .SEC_W        (SEC_W),
      .DEFAULT_HOUR (DEFAULT_HOUR),
      .DEFAULT_MIN  (DEFAULT_MIN)
   ) u_hm_reg (
      .clk        (Clk_10hz),
      .rst_n      (n_Global_Rst),
      .hour_inc_i (hour_inc),
      .min_inc_i  (min_inc),
      .sec_o      (Alarm_Sec_Cnt)
   );

   assign stop_k    = Key_Stop;
   assign mode_k    = Key_Mode & ~Key_Stop;
   assign adj_k     = Key_Adj & ~Key_Stop & ~Key_Mode;
   assign any_key   = Key_Mode | Key_Adj | Key_Stop;
   assign eq        = (Clock_Sec_Cnt == Alarm_Sec_Cnt);
   assign rise      = eq & ~eq_q;
   assign in_edit   = (state_q == ST_SET_HOUR) || (state_q == ST_SET_MIN);
   assign timed     = in_edit || (state_q == ST_RING) || (state_q == ST_SNOOZE);
   assign edit_tmo  = in_edit && !any_key && (cnt_q == EDIT_LAST);
   assign edit_exit = Alarm_En ? ST_ARMED : ST_IDLE;

   always_comb begin
      // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
      state_d  = state_q;
      hour_inc = 1'b0;
      min_inc  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (mode_k)        state_d = ST_SET_HOUR;
            else if (Alarm_En) state_d = ST_ARMED;
         end
         ST_SET_HOUR: begin
            if (mode_k)        state_d = ST_SET_MIN;
            else if (adj_k)    hour_inc = 1'b1;
            else if (edit_tmo) state_d = edit_exit;
         end
         ST_SET_MIN: begin
            if (mode_k || edit_tmo) state_d = edit_exit;
            else if (adj_k)         min_inc = 1'b1;
         end
         ST_ARMED: begin
            if (!Alarm_En)   state_d = ST_IDLE;
            else if (mode_k) state_d = ST_SET_HOUR;
            else if (rise)   state_d = ST_RING;
         end
         ST_RING: begin
            if (!Alarm_En)                state_d = ST_IDLE;
            else if (stop_k)              state_d = ST_ARMED;
`ifdef ALARM_SNOOZE_EN
            else if (adj_k)               state_d = ST_SNOOZE;
`endif
            else if (cnt_q == RING_LAST)  state_d = ST_ARMED;
         end
`ifdef ALARM_SNOOZE_EN
         ST_SNOOZE: begin
            if (!Alarm_En)                 state_d = ST_IDLE;
            else if (stop_k)               state_d = ST_ARMED;
            else if (cnt_q == SNOOZE_LAST) state_d = ST_RING;
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   // One shared dwell counter: restarts on every state change and on any key while editing.
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (!timed || (state_d != state_q) || (in_edit && any_key))
         cnt_d = '0;
   end

   // eq_q resets high so a time equal to the alarm at reset release is not a rise.
   always_ff @(posedge Clk_10hz or negedge n_Global_Rst) begin
      if (!n_Global_Rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         eq_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         eq_q    <= eq;
      end
   end

   assign Ring_Req   = (state_q == ST_RING);
   assign Edit_Field = {state_q == ST_SET_MIN, state_q == ST_SET_HOUR};
   assign State      = state_q;

endmodule

// File: tb/tb_alarm_sched_ctrl.sv
// Directed self-checking bench for alarm_sched_ctrl with default parameters.
// Covers both builds: behaviour in RING on Key_Adj follows ALARM_SNOOZE_EN.
module tb_alarm_sched_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        key_mode, key_adj, key_stop, alarm_en;
   logic [16:0] clock_sec;
   logic [16:0] alarm_sec;
   logic        ring_req;
   logic [1:0]  edit_field;
   logic [2:0]  state;

   int tests  = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alarm_sched_ctrl dut (
      .Clk_10hz      (clk),
      .n_Global_Rst  (rst_n),
      .Key_Mode      (key_mode),
      .Key_Adj       (key_adj),
      .Key_Stop      (key_stop),
      .Alarm_En      (alarm_en),
      .Clock_Sec_Cnt (clock_sec),
      .Alarm_Sec_Cnt (alarm_sec),
      .Ring_Req      (ring_req),
      .Edit_Field    (edit_field),
      .State         (state)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic press(input logic m, input logic a, input logic s);
      key_mode = m;
      key_adj  = a;
      key_stop = s;
      step();
      key_mode = 1'b0;
      key_adj  = 1'b0;
      key_stop = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      key_mode  = 1'b0;
      key_adj   = 1'b0;
      key_stop  = 1'b0;
      alarm_en  = 1'b1;
      clock_sec = 17'd3660;
      tick(2);
      check("rst_state", 32'(state), 0);
      check("rst_alarm", 32'(alarm_sec), 3660);
      check("rst_ring", 32'(ring_req), 0);
      check("rst_edit", 32'(edit_field), 0);

      // Reset release with clock equal to alarm: arm but do not ring.
      rst_n = 1'b1;
      step();
      check("armed_after_rst", 32'(state), 3);
      tick(3);
      check("no_ring_at_release", 32'(ring_req), 0);
      clock_sec = 17'd3661;
      step();
      clock_sec = 17'd3660;
      step();
      check("rise_ring_req", 32'(ring_req), 1);
      check("rise_state", 32'(state), 4);
      press(1'b0, 1'b0, 1'b1);
      check("stop_ring_req", 32'(ring_req), 0);
      check("stop_state", 32'(state), 3);
      step();
      check("no_retrigger_eq_held", 32'(state), 3);

      // Full wrap of hour and minute.
      press(1'b1, 1'b0, 1'b0);
      check("edit_hour_state", 32'(state), 1);
      check("edit_hour_field", 32'(edit_field), 1);
      press(1'b0, 1'b1, 1'b0);
      check("hour_inc_1", 32'(alarm_sec), 7260);
      for (int i = 0; i < 22; i++) press(1'b0, 1'b1, 1'b0);
      check("hour_wrap", 32'(alarm_sec), 60);
      press(1'b1, 1'b0, 1'b0);
      check("edit_min_state", 32'(state), 2);
      check("edit_min_field", 32'(edit_field), 2);
      for (int i = 0; i < 58; i++) press(1'b0, 1'b1, 1'b0);
      check("min_59", 32'(alarm_sec), 3540);
      press(1'b0, 1'b1, 1'b0);
      check("min_wrap", 32'(alarm_sec), 0);
      press(1'b1, 1'b0, 1'b0);
      check("edit_exit_armed", 32'(state), 3);
      check("edit_exit_field", 32'(edit_field), 0);

      // Set 07:00 and ring for exactly 600 cycles; Key_Mode ignored in RING.
      press(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) press(1'b0, 1'b1, 1'b0);
      press(1'b1, 1'b0, 1'b0);
      press(1'b1, 1'b0, 1'b0);
      check("alarm_0700", 32'(alarm_sec), 25200);
      check("armed_0700", 32'(state), 3);
      clock_sec = 17'd25199;
      step();
      check("no_ring_before", 32'(ring_req), 0);
      clock_sec = 17'd25200;
      step();
      check("ring_0700", 32'(ring_req), 1);
      tick(299);
      press(1'b1, 1'b0, 1'b0);
      check("mode_ignored_ring", 32'(state), 4);
      tick(299);
      check("ring_last_cycle", 32'(ring_req), 1);
      step();
      check("ring_timeout_req", 32'(ring_req), 0);
      check("ring_timeout_state", 32'(state), 3);

      // Snooze behaviour, or Key_Adj ignored without the feature.
      clock_sec = 17'd25199;
      step();
      clock_sec = 17'd25200;
      step();
      check("ring_again", 32'(ring_req), 1);
      press(1'b0, 1'b1, 1'b0);
`ifdef ALARM_SNOOZE_EN
      check("snooze_state", 32'(state), 5);
      check("snooze_req", 32'(ring_req), 0);
      tick(2999);
      check("snooze_last_cycle", 32'(ring_req), 0);
      step();
      check("snooze_to_ring", 32'(ring_req), 1);
      check("snooze_to_ring_st", 32'(state), 4);
      press(1'b0, 1'b1, 1'b1);
      check("stop_beats_adj", 32'(state), 3);
      clock_sec = 17'd25199;
      step();
      clock_sec = 17'd25200;
      step();
      press(1'b0, 1'b1, 1'b0);
      check("snooze_again", 32'(state), 5);
      tick(5);
      alarm_en = 1'b0;
      step();
      check("snooze_dis_state", 32'(state), 0);
      check("snooze_dis_req", 32'(ring_req), 0);
`else
      check("adj_ignored_state", 32'(state), 4);
      check("adj_ignored_req", 32'(ring_req), 1);
      press(1'b0, 1'b1, 1'b1);
      check("stop_beats_adj", 32'(state), 3);
      clock_sec = 17'd25199;
      step();
      clock_sec = 17'd25200;
      step();
      check("ring_third", 32'(ring_req), 1);
      alarm_en = 1'b0;
      step();
      check("ring_dis_state", 32'(state), 0);
      check("ring_dis_req", 32'(ring_req), 0);
`endif

      // Edit timeout from SET_HOUR keeps the edited hour; Alarm_En toggling does not abort.
      press(1'b1, 1'b0, 1'b0);
      check("tmo_enter", 32'(state), 1);
      press(1'b0, 1'b1, 1'b0);
      check("tmo_hour8", 32'(alarm_sec), 28800);
      tick(50);
      alarm_en = 1'b1;
      tick(10);
      alarm_en = 1'b0;
      tick(39);
      check("tmo_not_yet", 32'(state), 1);
      step();
      check("tmo_idle", 32'(state), 0);
      check("tmo_hour_kept", 32'(alarm_sec), 28800);

      // Asynchronous reset while ringing.
      alarm_en = 1'b1;
      step();
      check("rearm", 32'(state), 3);
      clock_sec = 17'd28799;
      step();
      clock_sec = 17'd28800;
      step();
      check("ring_pre_rst", 32'(ring_req), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_req", 32'(ring_req), 0);
      check("async_rst_state", 32'(state), 0);
      check("async_rst_alarm", 32'(alarm_sec), 3660);
      step();
      rst_n = 1'b1;
      step();

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule

// File: doc/alarm_sched_ctrl.md
# alarm_sched_ctrl

Sequencing controller for the alarm path of the digital clock. It owns the alarm hour/minute setting and runs the edit → armed → ring → snooze lifecycle from three debounced key pulses and an enable switch. It sits between the key debouncers and the beeper driver (Flash2 pattern generator) and replaces direct Load/increment steering of the alarm register. All logic runs in the 10 Hz domain.

## Interface
- SEC_W, 17, width of seconds-of-day values
- DEFAULT_HOUR, 1, alarm hour after reset
- DEFAULT_MIN, 1, alarm minute after reset (reset alarm = 3660 s)
- EDIT_TIMEOUT, 100, idle cycles in an edit state before auto-exit (10 s)
- RING_TICKS, 600, cycles RING lasts before auto-stop (60 s)
- SNOOZE_TICKS, 3000, cycles spent in SNOOZE (5 min)

- Clk_10hz  in  1  system clock, 10 Hz, rising edge
- n_Global_Rst  in  1  reset, asynchronous, active-low
- Key_Mode  in  1  one-cycle pulse: enter/advance edit
- Key_Adj  in  1  one-cycle pulse: increment field / snooze
- Key_Stop  in  1  one-cycle pulse: silence alarm
- Alarm_En  in  1  level switch: alarm armed when 1
- Clock_Sec_Cnt  in  SEC_W  current time of day, 0..86399
- Alarm_Sec_Cnt  out  SEC_W  alarm time = hour*3600 + min*60
- Ring_Req  out  1  beeper request, high in RING
- Edit_Field  out  2  one-hot: [0] hour editing, [1] minute editing, for display blink
- State  out  3  current state code, for debug/display

## Operation
- States: IDLE=0, SET_HOUR=1, SET_MIN=2, ARMED=3, RING=4, SNOOZE=5.
- Key priority when coincident: Key_Stop > Key_Mode > Key_Adj; lower keys ignored that cycle.
- IDLE: Key_Mode → SET_HOUR; else Alarm_En=1 → ARMED.
- SET_HOUR: Key_Adj → hour = (hour==23) ? 0 : hour+1. Key_Mode → SET_MIN.
- SET_MIN: Key_Adj → min = (min==59) ? 0 : min+1, hour unchanged. Key_Mode → ARMED if Alarm_En else IDLE.
- Edit timeout: idle counter cleared on entry and on every key; reaching EDIT_TIMEOUT exits as Key_Mode from SET_MIN does (edits kept). Alarm_En changes do not abort editing.
- ARMED: Key_Mode → SET_HOUR; Alarm_En=0 → IDLE; match rise → RING.
- Match: eq = (Clock_Sec_Cnt == Alarm_Sec_Cnt); eq_d registered every cycle in all states; rise = eq & ~eq_d. Only a rise seen while in ARMED triggers. Returning to ARMED while eq already 1 does not ring.
- RING: Key_Stop → ARMED; Key_Adj → SNOOZE (see Configuration); ring counter reaching RING_TICKS → ARMED; Alarm_En=0 → IDLE. Key_Mode ignored.
- SNOOZE: counter reaching SNOOZE_TICKS → RING (ring counter restarted); Key_Stop → ARMED; Alarm_En=0 → IDLE. Unlimited snoozes.
- Alarm_En=0 has priority over all RING/SNOOZE/ARMED transitions.
- Alarm seconds field always 0; Alarm_Sec_Cnt never exceeds 86340.

## Timing
- Reset (async assert, sync release): State=IDLE, hour/min=DEFAULT, Alarm_Sec_Cnt=3660, Ring_Req=0, Edit_Field=00, all counters 0, eq_d=1 (no ring if time equals alarm at reset release).
- Key_Adj at cycle N → Alarm_Sec_Cnt updated at N+1.
- Match rise at cycle N → State=RING and Ring_Req=1 at N+1 (Ring_Req decoded from state register, no extra latency).
- Key_Stop in RING at N → Ring_Req=0 at N+1.
- Counters compare with ==, count from 0 on state entry; RING ends exactly RING_TICKS cycles after entry.
- Reset mid-RING/SNOOZE: Ring_Req drops asynchronously with reset.

## Configuration
- ALARM_SNOOZE_EN defined: Key_Adj in RING → SNOOZE, behaviour as above.
- Not defined: SNOOZE state and its counter not built; Key_Adj in RING ignored; State never 5.

## Structure
- Package alarm_sched_pkg: state codes, SEC_PER_HOUR=3600, SEC_PER_MIN=60, DAY_LAST_SEC=86399, HOUR_MAX=23, MIN_MAX=59.
- Sub-module alarm_hm_reg: hour/minute registers with wrap increments and seconds-of-day conversion; FSM, counters and match detect stay in the top.

## Test plan
- Reset release, Clock_Sec_Cnt=3660, Alarm_En=1 → ARMED, no Ring_Req; time moves to 3661 then back to 3660 → RING next cycle.
- Mode, Adj×23, Mode, Adj×59, Mode → Alarm_Sec_Cnt = 0*3600+0*60 = 0 (hour 1+23 wraps to 0, min 1+59 wraps to 0), State=ARMED.
- ARMED, alarm 25200, clock steps 25199→25200 → Ring_Req=1 next cycle, drops exactly 600 cycles later, State=ARMED.
- RING, Key_Adj → SNOOZE, Ring_Req=0; 3000 cycles later Ring_Req=1 (with ALARM_SNOOZE_EN); without macro Key_Adj keeps RING.
- SET_HOUR, no keys for 100 cycles, Alarm_En=0 → IDLE with edited hour retained.
- RING, Key_Stop and Key_Adj same cycle → ARMED; Alarm_En=0 during SNOOZE → IDLE, Ring_Req stays 0.
